// File: rtl/fifo_wr_arbiter_if.sv
// Write-port bundle shared by NUM_REQ producers, the burst arbiter and the line/frame FIFO.
// The arbiter masters the FIFO write port; producers and the FIFO sit on the slave side.
interface fifo_wr_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4
);
    localparam int ID_WIDTH = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid_i;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i;
    logic [NUM_REQ-1:0]            req_last_i;
    logic [NUM_REQ-1:0]            req_ready_o;
    logic                          fifo_wr_valid_o;
    logic [DATA_WIDTH-1:0]         fifo_data_o;
    logic [ID_WIDTH-1:0]           fifo_id_o;
    logic                          fifo_full_i;

    modport master (
        input  req_valid_i, req_data_i, req_last_i, fifo_full_i,
        output req_ready_o, fifo_wr_valid_o, fifo_data_o, fifo_id_o
    );

    modport slave (
        output req_valid_i, req_data_i, req_last_i, fifo_full_i,
        input  req_ready_o, fifo_wr_valid_o, fifo_data_o, fifo_id_o
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter: one producer owns the FIFO write port for a whole burst
// (or MAX_BURST beats), and every beat it writes is tagged with its requester ID.
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 16
) (
    input  logic               clk,
    input  logic               rst,
    fifo_wr_arbiter_if.master  bus,
    output logic [NUM_REQ-1:0] grant_o,
    output logic               busy_o
);
    localparam int ID_WIDTH  = $clog2(NUM_REQ);
    localparam int CNT_WIDTH = $clog2(MAX_BURST + 1);

    localparam logic [CNT_WIDTH-1:0] CNT_CAP   = CNT_WIDTH'(MAX_BURST - 1);
    localparam logic [ID_WIDTH-1:0]  LAST_INIT = ID_WIDTH'(NUM_REQ - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]            state;
    logic [ID_WIDTH-1:0]   gnt_id;
    logic [ID_WIDTH-1:0]   last_winner;
    logic [CNT_WIDTH-1:0]  beat_cnt;

    logic [ID_WIDTH-1:0]   winner;
    logic [ID_WIDTH-1:0]   cand;
    logic                  found;
    logic                  hs;
    logic                  release_burst;
    logic [DATA_WIDTH-1:0] req_data_a [NUM_REQ];

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            req_data_a[k] = bus.req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Search upward from the requester after the last winner, wrapping at NUM_REQ.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        winner = '0;
        cand   = '0;
        found  = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (int'(last_winner) + i >= NUM_REQ) begin
                cand = ID_WIDTH'(int'(last_winner) + i - NUM_REQ);
            end else begin
                cand = ID_WIDTH'(int'(last_winner) + i);
            end
            if (!found && bus.req_valid_i[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign hs            = (state == GRANT) && bus.req_valid_i[gnt_id] && !bus.fifo_full_i;
    assign release_burst = hs && (bus.req_last_i[gnt_id] || (beat_cnt == CNT_CAP));
    assign busy_o        = (state == GRANT);

    always_comb begin
        bus.fifo_wr_valid_o = hs;
        bus.fifo_data_o     = '0;
        bus.fifo_id_o       = '0;
        bus.req_ready_o     = '0;
        if (state == GRANT) begin
            bus.fifo_data_o             = req_data_a[gnt_id];
            bus.fifo_id_o               = gnt_id;
            bus.req_ready_o[gnt_id]     = !bus.fifo_full_i;
        end
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            grant_o     <= '0;
            gnt_id      <= '0;
            last_winner <= LAST_INIT;
            beat_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state       <= GRANT;
                        grant_o     <= NUM_REQ'(1) << winner;
                        gnt_id      <= winner;
                        last_winner <= winner;
                        beat_cnt    <= '0;
                    end
                end
                GRANT: begin
                    if (release_burst) begin
                        state    <= IDLE;
                        grant_o  <= '0;
                        beat_cnt <= '0;
                    end else if (hs && (beat_cnt != CNT_CAP)) begin
                        beat_cnt <= beat_cnt + CNT_WIDTH'(1);
                    end
                end
            endcase
        end
    end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares one sync FIFO write port between NUM_REQ producer streams.
- Holds a grant for a whole burst, so one requester's beats land contiguously in the FIFO.
- Each burst is tagged with the requester ID.
- Sits in front of the line/frame buffer FIFO in the frame-fetch path and drives the FIFO's data_i/wr_valid_i from its own outputs.

Parameters:
- DATA_WIDTH, 8, payload width per beat.
- NUM_REQ, 4, number of requesters (>=2).
- MAX_BURST, 16, maximum beats per grant; forced release after this many (>=1).
- ID_WIDTH, $clog2(NUM_REQ), requester-ID width (derived, do not configure).
- CNT_WIDTH, $clog2(MAX_BURST+1), beat-counter width (derived).

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- req_valid_i  input  NUM_REQ  per-requester beat valid.
- req_data_i  input  NUM_REQ*DATA_WIDTH  packed payloads; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- req_last_i  input  NUM_REQ  final beat of requester's burst.
- req_ready_o  output  NUM_REQ  per-requester ready, combinational.
- fifo_wr_valid_o  output  1  write strobe to FIFO.
- fifo_data_o  output  DATA_WIDTH  beat to FIFO.
- fifo_id_o  output  ID_WIDTH  ID of the granted requester.
- fifo_full_i  input  1  FIFO full flag.
- grant_o  output  NUM_REQ  registered one-hot grant, all zero when idle.
- busy_o  output  1  high in state GRANT.

Behaviour:
- State machine, two states:
  - IDLE: if any req_valid_i bit is set, pick the winner and register it into grant_o / gnt_id; beat_cnt <= 0; go to GRANT. Otherwise stay in IDLE.
  - GRANT: stay until a release event, then go to IDLE.
- Latency: one cycle from request to grant. One idle bubble cycle between consecutive bursts.
- Winner selection:
  - Round-robin, starting at index (last_winner+1) mod NUM_REQ and searching upward with wrap.
  - last_winner updates when a grant is issued.
- Datapath in GRANT (g = granted index):
  - fifo_wr_valid_o = req_valid_i[g] & ~fifo_full_i.
  - fifo_data_o = req_data_i slice g.
  - fifo_id_o = g.
  - req_ready_o[g] = ~fifo_full_i; all other ready bits 0.
  - Handshake hs = req_valid_i[g] & ~fifo_full_i.
- Outside GRANT: fifo_wr_valid_o=0, req_ready_o=0, fifo_data_o=0, fifo_id_o=0.
- Beat counter: beat_cnt increments on hs and saturates logically at MAX_BURST-1.
- Release: on a cycle with hs AND (req_last_i[g] OR beat_cnt==MAX_BURST-1):
  - next state IDLE, grant_o <= 0, beat_cnt <= 0.
  - A forced release (cap reached without last) leaves the requester's remaining beats for its next grant.
- FIFO full: with fifo_full_i=1 there is no handshake and no counting; grant is held; the requester's valid/data must stay stable (AXI-style).
- A granted requester dropping valid: grant is held and no timeout applies; producers must not abandon a burst.
- req_last_i of non-granted requesters is ignored.
- Reset:
  - state=IDLE, grant_o=0, busy_o=0, beat_cnt=0.
  - last_winner=NUM_REQ-1, so requester 0 has first priority.
  - All outputs 0.
  - Reset asserted mid-burst aborts the grant on the next edge; beats already written remain in the FIFO.
- Invariants:
  - grant_o is one-hot or zero.
  - fifo_wr_valid_o is never 1 while fifo_full_i=1.
  - At most one req_ready_o bit is high.

Test Plan:
- Reset, then req_valid_i=4'b0001, 3 beats 0x11,0x12,0x13 with last on the third -> grant_o=0001 one cycle after request; FIFO receives 11,12,13 with id 0; grant_o=0 the cycle after the last handshake.
- All 4 requesters continuously valid, each burst 2 beats -> grant order 0,1,2,3,0; every burst contiguous in the FIFO; one bubble cycle between bursts.
- MAX_BURST=4, requester 2 sends 6 beats with last on the 6th, requester 3 also waiting -> 4 beats tagged id 2, then 3's burst, then the remaining 2 beats of requester 2.
- Grant to requester 1; fifo_full_i=1 for 5 cycles mid-burst -> fifo_wr_valid_o=0 and req_ready_o=0 during the stall; beat_cnt frozen; no beat lost or duplicated after full clears.
- rst asserted in the cycle after the 2nd of 4 beats -> next cycle grant_o=0, busy_o=0; after release, requester 0 is served first.
- Only requester 3 valid, with last_winner=3 -> wrap-around search grants 3 again; grant_o=1000.
